ticket_escrow_ctrl: RTL and testbench

Escrow and bill-handling controller that sits on the far side of the one-week ticket vendor FSM. It accepts validated bills from the bill validator, forwards them to the vendor as single-cycle Ten/Twenty pulses and holds them in escrow. It then executes the vendor's Dispense or Return verdict: it prints a ticket and stacks the escrowed bills to the cashbox, or it ejects them to the customer one at a time over req/ack handshakes.

---
 rtl/escrow_defs.sv | 40 ++++
 rtl/escrow_stack.sv | 70 +++++++
 rtl/ticket_escrow_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ticket_escrow_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/escrow_defs.sv
`default_nettype none
// ============================================================================
// Package     : escrow_defs
// Description : Shared types and constants for the ticket escrow controller:
//               controller state encoding, bill denomination encoding, dollar
//               values per bill and readability constants.
// Revision    : 1.0 - initial release
// ============================================================================
package escrow_defs;

  // Controller states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TICKET = 3'd1,
    STACK  = 3'd2,
    EJECT  = 3'd3,
    FAULT  = 3'd4
  } state_t;

  // Bill denomination as carried on BillValue / EjectValue
  typedef enum logic {
    BILL_10 = 1'b0,
    BILL_20 = 1'b1
  } bill_t;

  localparam logic [6:0] TEN_VALUE    = 7'd10;
  localparam logic [6:0] TWENTY_VALUE = 7'd20;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Dollar value of one bill given its denomination bit
  function automatic logic [6:0] bill_dollars(input logic value);
    return (value == BILL_20) ? TWENTY_VALUE : TEN_VALUE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/escrow_stack.sv
`default_nettype none
// ============================================================================
// Module      : escrow_stack
// Description : DEPTH-entry LIFO of bill denomination bits with a running
//               count and dollar total. Implemented as a shift register so
//               the top of stack is always bit 0 (no indexed read needed).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock      in   system clock, rising edge
//   Clear_n    in   asynchronous active-low reset
//   push       in   push push_value (ignored when full)
//   push_value in   denomination to push (0 = $10, 1 = $20)
//   pop        in   drop the top entry (ignored when empty)
//   top        out  denomination at top of stack (0 when empty)
//   count      out  number of entries held
//   total      out  dollar value of all entries held
// ============================================================================
module escrow_stack
  import escrow_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       Clock,
  input  logic                       Clear_n,
  input  logic                       push,
  input  logic                       push_value,
  input  logic                       pop,
  output logic                       top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [6:0]                 total
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_bits;
  logic [CW-1:0]    r_count;
  logic [6:0]       r_total;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = push && (r_count != CW'(DEPTH));
  assign w_do_pop  = pop && (r_count != '0);

  // Simultaneous push and pop never occurs from the controller; it is treated
  // as a no-op so the count and total stay consistent with the contents.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r_bits  <= '0;
      r_count <= '0;
      r_total <= '0;
    end else if (w_do_push && !w_do_pop) begin
      r_bits  <= {r_bits[DEPTH-2:0], push_value};
      r_count <= r_count + 1'b1;
      r_total <= r_total + bill_dollars(push_value);
    end else if (w_do_pop && !w_do_push) begin
      // Vacated slots shift in as zero so an empty stack reads top = 0
      r_bits  <= {1'b0, r_bits[DEPTH-1:1]};
      r_count <= r_count - 1'b1;
      r_total <= r_total - bill_dollars(r_bits[0]);
    end
  end

  assign top   = r_bits[0];
  assign count = r_count;
  assign total = r_total;

endmodule
`default_nettype wire

// File: rtl/ticket_escrow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ticket_escrow_ctrl
// Description : Escrow and bill-handling controller behind the ticket vendor
//               FSM. Accepts validated bills, pulses Ten/Twenty to the vendor,
//               holds bills in a LIFO escrow, then either prints a ticket and
//               stacks the bills or ejects them one by one. Every mechanism
//               request is guarded by an ack timeout that latches FAULT.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock, Clear_n              clock / async active-low reset
//   BillIn, BillValue           validator strobe and denomination
//   Ready, Bill                 vendor "may accept a bill" indications
//   Dispense, Return            vendor verdicts
//   Ten, Twenty, Reject         single-cycle pulses (vendor / validator)
//   TicketReq/TicketAck         ticket printer handshake
//   StackReq/StackAck           cashbox stacker handshake
//   EjectReq/EjectAck           eject motor handshake
//   EjectValue                  denomination being ejected
//   EscrowCount, EscrowTotal    escrow occupancy and dollar value
//   Busy, Fault                 not-IDLE flag and sticky timeout flag
// ============================================================================
module ticket_escrow_ctrl
  import escrow_defs::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic                       Clock,
  input  logic                       Clear_n,
  input  logic                       BillIn,
  input  logic                       BillValue,
  input  logic                       Ready,
  input  logic                       Bill,
  input  logic                       Dispense,
  input  logic                       Return,
  output logic                       Ten,
  output logic                       Twenty,
  output logic                       Reject,
  output logic                       TicketReq,
  input  logic                       TicketAck,
  output logic                       StackReq,
  input  logic                       StackAck,
  output logic                       EjectReq,
  input  logic                       EjectAck,
  output logic                       EjectValue,
  output logic [$clog2(DEPTH+1)-1:0] EscrowCount,
  output logic [6:0]                 EscrowTotal,
  output logic                       Busy,
  output logic                       Fault
);

  localparam int            CW             = $clog2(DEPTH + 1);
  localparam int            TW             = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] c_timeout_last = TW'(ACK_TIMEOUT - 1);

  state_t        r_state;
  logic          r_ten;
  logic          r_twenty;
  logic          r_reject;
  logic          r_ticket_req;
  logic          r_stack_req;
  logic          r_eject_req;
  logic          r_eject_value;
  logic          r_busy;
  logic          r_fault;
  logic [TW-1:0] r_timer;

  logic          w_accept;
  logic          w_pop;
  logic          w_timeout;
  logic          w_top;
  logic [CW-1:0] w_count;
  logic [6:0]    w_total;

  // A bill is only taken in IDLE, when the vendor can take money, when there
  // is room, and when no verdict arrives in the same cycle.
  assign w_accept = BillIn && (r_state == IDLE) && (Ready || Bill) &&
                    !Dispense && !Return && (w_count < CW'(DEPTH));

  // Pops happen on the edge that samples the ack of the current request
  assign w_pop = ((r_state == STACK) && r_stack_req && StackAck) ||
                 ((r_state == EJECT) && r_eject_req && EjectAck);

  // Counter reaches ACK_TIMEOUT on this edge without an ack
  assign w_timeout = (r_timer == c_timeout_last);

  escrow_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .Clock      (Clock),
    .Clear_n    (Clear_n),
    .push       (w_accept),
    .push_value (BillValue),
    .pop        (w_pop),
    .top        (w_top),
    .count      (w_count),
    .total      (w_total)
  );

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r_state       <= IDLE;
      r_ten         <= OFF;
      r_twenty      <= OFF;
      r_reject      <= OFF;
      r_ticket_req  <= OFF;
      r_stack_req   <= OFF;
      r_eject_req   <= OFF;
      r_eject_value <= OFF;
      r_busy        <= OFF;
      r_fault       <= OFF;
      r_timer       <= '0;
    end else begin
      // Bill response pulses last exactly one cycle
      r_ten    <= OFF;
      r_twenty <= OFF;
      r_reject <= OFF;
      if (BillIn) begin
        if (w_accept) begin
          r_ten    <= (BillValue == BILL_10);
          r_twenty <= (BillValue == BILL_20);
        end else begin
          r_reject <= ON;
        end
      end

      case (r_state)
        IDLE: begin
          // Return has priority over Dispense
          if (Return) begin
            r_state <= EJECT;
            r_busy  <= ON;
            if (w_count != '0) begin
              r_eject_req   <= ON;
              r_eject_value <= w_top;
              r_timer       <= '0;
            end
          end else if (Dispense) begin
            r_state      <= TICKET;
            r_busy       <= ON;
            r_ticket_req <= ON;
            r_timer      <= '0;
          end
        end

        TICKET: begin
          if (TicketAck) begin
            r_ticket_req <= OFF;
            if (w_count == '0) begin
              r_state <= IDLE;
              r_busy  <= OFF;
            end else begin
              // StackReq rises one cycle later, leaving a gap between Reqs
              r_state <= STACK;
            end
          end else if (w_timeout) begin
            r_state      <= FAULT;
            r_fault      <= ON;
            r_ticket_req <= OFF;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        STACK: begin
          if (!r_stack_req) begin
            r_stack_req <= ON;
            r_timer     <= '0;
          end else if (StackAck) begin
            r_stack_req <= OFF;
            if (w_count == CW'(1)) begin
              r_state <= IDLE;
              r_busy  <= OFF;
            end
          end else if (w_timeout) begin
            r_state     <= FAULT;
            r_fault     <= ON;
            r_stack_req <= OFF;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        EJECT: begin
          if (!r_eject_req) begin
            // An empty escrow (Return with nothing held) leaves after one cycle
            if (w_count == '0) begin
              r_state <= IDLE;
              r_busy  <= OFF;
            end else begin
              r_eject_req   <= ON;
              r_eject_value <= w_top;
              r_timer       <= '0;
            end
          end else if (EjectAck) begin
            r_eject_req   <= OFF;
            r_eject_value <= OFF;
            if (w_count == CW'(1)) begin
              r_state <= IDLE;
              r_busy  <= OFF;
            end
          end else if (w_timeout) begin
            r_state       <= FAULT;
            r_fault       <= ON;
            r_eject_req   <= OFF;
            r_eject_value <= OFF;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        FAULT: begin
          // Held until Clear_n; escrow is left untouched
          r_busy  <= ON;
          r_fault <= ON;
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= OFF;
        end
      endcase
    end
  end

  assign Ten         = r_ten;
  assign Twenty      = r_twenty;
  assign Reject      = r_reject;
  assign TicketReq   = r_ticket_req;
  assign StackReq    = r_stack_req;
  assign EjectReq    = r_eject_req;
  assign EjectValue  = r_eject_value;
  assign EscrowCount = w_count;
  assign EscrowTotal = w_total;
  assign Busy        = r_busy;
  assign Fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ticket_escrow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ticket_escrow_ctrl
// Description : Self-checking bench for ticket_escrow_ctrl. Expected bill
//               pulses and eject denominations are queued when stimulus is
//               driven and compared when the DUT produces them; mechanism
//               acks come from a small auto-responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ticket_escrow_ctrl;

  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 20;
  localparam int CW          = $clog2(DEPTH + 1);

  localparam logic [2:0] c_p_ten    = 3'b001;
  localparam logic [2:0] c_p_twenty = 3'b010;
  localparam logic [2:0] c_p_rej    = 3'b100;

  logic Clock = 1'b0;
  logic Clear_n = 1'b0;
  logic BillIn = 1'b0, BillValue = 1'b0, Ready = 1'b0, Bill = 1'b0;
  logic Dispense = 1'b0, Return = 1'b0;
  logic TicketAck = 1'b0, StackAck = 1'b0, EjectAck = 1'b0;
  logic Ten, Twenty, Reject, TicketReq, StackReq, EjectReq, EjectValue;
  logic [CW-1:0] EscrowCount;
  logic [6:0]    EscrowTotal;
  logic Busy, Fault;

  always #5 Clock = ~Clock;

  ticket_escrow_ctrl #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .Clock       (Clock),
    .Clear_n     (Clear_n),
    .BillIn      (BillIn),
    .BillValue   (BillValue),
    .Ready       (Ready),
    .Bill        (Bill),
    .Dispense    (Dispense),
    .Return      (Return),
    .Ten         (Ten),
    .Twenty      (Twenty),
    .Reject      (Reject),
    .TicketReq   (TicketReq),
    .TicketAck   (TicketAck),
    .StackReq    (StackReq),
    .StackAck    (StackAck),
    .EjectReq    (EjectReq),
    .EjectAck    (EjectAck),
    .EjectValue  (EjectValue),
    .EscrowCount (EscrowCount),
    .EscrowTotal (EscrowTotal),
    .Busy        (Busy),
    .Fault       (Fault)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [2:0] q_pulse[$];
  logic       q_eject[$];

  int   ticket_rises = 0, stack_rises = 0, eject_rises = 0;
  logic prev_t = 1'b0, prev_s = 1'b0, prev_e = 1'b0;
  logic auto_ticket = 1'b1, auto_stack = 1'b1, auto_eject = 1'b1, spur = 1'b0;
  logic [2:0] code, exp_code;
  logic       exp_val;

  task automatic check_value(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  // Scoreboard side: compare pulses and eject starts as they appear
  always @(negedge Clock) begin
    if (Clear_n) begin
      code = {Reject, Twenty, Ten};
      if (code != 3'b000) begin
        if (q_pulse.size() == 0) check_value("pulse_unexpected", int'(code), 0);
        else begin
          exp_code = q_pulse.pop_front();
          check_value("bill_pulse", int'(code), int'(exp_code));
        end
      end
      check_value("one_req_at_a_time",
                  int'((int'(TicketReq) + int'(StackReq) + int'(EjectReq)) > 1), 0);
      if (EjectReq && !prev_e) begin
        eject_rises++;
        if (q_eject.size() == 0) check_value("eject_unexpected", 1, 0);
        else begin
          exp_val = q_eject.pop_front();
          check_value("eject_value", int'(EjectValue), int'(exp_val));
        end
      end
      if (TicketReq && !prev_t) ticket_rises++;
      if (StackReq && !prev_s)  stack_rises++;
    end
    prev_t = TicketReq;
    prev_s = StackReq;
    prev_e = EjectReq;
  end

  // Mechanism responder: acks follow the request shortly after the negedge
  always @(negedge Clock) begin
    #2;
    TicketAck = (auto_ticket & TicketReq) | spur;
    StackAck  = (auto_stack  & StackReq)  | spur;
    EjectAck  = (auto_eject  & EjectReq)  | spur;
  end

  task automatic send_bill(input logic v, input logic [2:0] expect_pulse);
    q_pulse.push_back(expect_pulse);
    BillIn    = 1'b1;
    BillValue = v;
    tick();
    BillIn    = 1'b0;
    BillValue = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 200) begin
      tick();
      n++;
    end
    check_value({tag, "_back_to_idle"}, int'(Busy), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_value({tag, "_Ten"},        int'(Ten), 0);
    check_value({tag, "_Twenty"},     int'(Twenty), 0);
    check_value({tag, "_Reject"},     int'(Reject), 0);
    check_value({tag, "_TicketReq"},  int'(TicketReq), 0);
    check_value({tag, "_StackReq"},   int'(StackReq), 0);
    check_value({tag, "_EjectReq"},   int'(EjectReq), 0);
    check_value({tag, "_EjectValue"}, int'(EjectValue), 0);
    check_value({tag, "_Count"},      int'(EscrowCount), 0);
    check_value({tag, "_Total"},      int'(EscrowTotal), 0);
    check_value({tag, "_Busy"},       int'(Busy), 0);
    check_value({tag, "_Fault"},      int'(Fault), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int t0, s0, e0, n;

    // Reset state
    repeat (2) tick();
    check_zero_outputs("reset");
    Clear_n = 1'b1;
    tick();

    // $10,$10,$20 then Dispense
    Ready = 1'b1;
    Bill  = 1'b1;
    send_bill(1'b0, c_p_ten);
    send_bill(1'b0, c_p_ten);
    send_bill(1'b1, c_p_twenty);
    check_value("load3_total", int'(EscrowTotal), 40);
    check_value("load3_count", int'(EscrowCount), 3);
    t0 = ticket_rises;
    s0 = stack_rises;
    Dispense = 1'b1;
    tick();
    Dispense = 1'b0;
    check_value("dispense_busy", int'(Busy), 1);
    check_value("dispense_ticketreq", int'(TicketReq), 1);
    wait_idle("dispense");
    check_value("dispense_ticket_reqs", ticket_rises - t0, 1);
    check_value("dispense_stack_reqs", stack_rises - s0, 3);
    check_value("dispense_count", int'(EscrowCount), 0);
    check_value("dispense_total", int'(EscrowTotal), 0);

    // Overpay: fill to DEPTH, reject the 5th, then Return in LIFO order
    send_bill(1'b0, c_p_ten);
    send_bill(1'b0, c_p_ten);
    send_bill(1'b0, c_p_ten);
    send_bill(1'b1, c_p_twenty);
    check_value("full_count", int'(EscrowCount), 4);
    check_value("full_total", int'(EscrowTotal), 50);
    send_bill(1'b1, c_p_rej);
    check_value("fifth_bill_count", int'(EscrowCount), 4);
    check_value("fifth_bill_total", int'(EscrowTotal), 50);
    e0 = eject_rises;
    q_eject.push_back(1'b1);
    q_eject.push_back(1'b0);
    q_eject.push_back(1'b0);
    q_eject.push_back(1'b0);
    Return = 1'b1;
    tick();
    Return = 1'b0;
    check_value("return_busy", int'(Busy), 1);
    wait_idle("overpay");
    check_value("overpay_eject_reqs", eject_rises - e0, 4);
    check_value("overpay_count", int'(EscrowCount), 0);

    // BillIn during STACK, then withheld StackAck until timeout
    auto_stack = 1'b0;
    send_bill(1'b1, c_p_twenty);
    Dispense = 1'b1;
    tick();
    Dispense = 1'b0;
    n = 0;
    while (!StackReq && n < 50) begin
      tick();
      n++;
    end
    check_value("stackreq_seen", int'(StackReq), 1);
    send_bill(1'b0, c_p_rej);
    check_value("stack_busy_reject_count", int'(EscrowCount), 1);
    repeat (ACK_TIMEOUT - 2) tick();
    check_value("pre_timeout_fault", int'(Fault), 0);
    check_value("pre_timeout_stackreq", int'(StackReq), 1);
    tick();
    check_value("timeout_fault", int'(Fault), 1);
    check_value("timeout_stackreq", int'(StackReq), 0);
    check_value("timeout_busy", int'(Busy), 1);
    check_value("timeout_count", int'(EscrowCount), 1);
    check_value("timeout_total", int'(EscrowTotal), 20);
    send_bill(1'b1, c_p_rej);
    tick();
    check_value("fault_reject_count", int'(EscrowCount), 1);
    check_value("fault_sticky", int'(Fault), 1);
    #3 Clear_n = 1'b0;
    #1 check_zero_outputs("fault_clear");
    @(negedge Clock);
    Clear_n    = 1'b1;
    auto_stack = 1'b1;
    tick();

    // Dispense, Return and BillIn together: Return wins, bill refused
    send_bill(1'b0, c_p_ten);
    t0 = ticket_rises;
    e0 = eject_rises;
    q_pulse.push_back(c_p_rej);
    q_eject.push_back(1'b0);
    BillIn    = 1'b1;
    BillValue = 1'b1;
    Dispense  = 1'b1;
    Return    = 1'b1;
    tick();
    BillIn    = 1'b0;
    BillValue = 1'b0;
    Dispense  = 1'b0;
    Return    = 1'b0;
    check_value("simul_ticketreq", int'(TicketReq), 0);
    check_value("simul_ejectreq", int'(EjectReq), 1);
    wait_idle("simul");
    check_value("simul_ticket_reqs", ticket_rises - t0, 0);
    check_value("simul_eject_reqs", eject_rises - e0, 1);
    check_value("simul_count", int'(EscrowCount), 0);

    // Return with empty escrow: one EJECT cycle, no EjectReq
    Return = 1'b1;
    tick();
    Return = 1'b0;
    check_value("empty_return_busy", int'(Busy), 1);
    check_value("empty_return_ejectreq", int'(EjectReq), 0);
    tick();
    check_value("empty_return_idle", int'(Busy), 0);
    check_value("empty_return_ejectreq2", int'(EjectReq), 0);

    // Acks with no request pending are ignored
    send_bill(1'b0, c_p_ten);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    check_value("spurious_ack_busy", int'(Busy), 0);
    check_value("spurious_ack_count", int'(EscrowCount), 1);

    // Vendor not ready: bill refused
    Ready = 1'b0;
    Bill  = 1'b0;
    send_bill(1'b1, c_p_rej);
    check_value("not_ready_count", int'(EscrowCount), 1);
    Ready = 1'b1;

    // Mid-operation reset during EJECT
    send_bill(1'b1, c_p_twenty);
    auto_eject = 1'b0;
    q_eject.push_back(1'b1);
    Return = 1'b1;
    tick();
    Return = 1'b0;
    check_value("midop_ejectreq", int'(EjectReq), 1);
    check_value("midop_ejectvalue", int'(EjectValue), 1);
    tick();
    #3 Clear_n = 1'b0;
    #1 check_zero_outputs("midop_reset");
    @(negedge Clock);
    Clear_n    = 1'b1;
    auto_eject = 1'b1;
    tick();
    check_value("post_reset_busy", int'(Busy), 0);
    send_bill(1'b1, c_p_twenty);
    check_value("post_reset_count", int'(EscrowCount), 1);
    check_value("post_reset_total", int'(EscrowTotal), 20);
    q_eject.push_back(1'b1);
    Return = 1'b1;
    tick();
    Return = 1'b0;
    wait_idle("post_reset_return");
    check_value("post_reset_final_count", int'(EscrowCount), 0);

    repeat (3) tick();
    check_value("pulse_queue_drained", q_pulse.size(), 0);
    check_value("eject_queue_drained", q_eject.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
